// File: rtl/comma_word_aligner.sv
// Serial 8b/10b word aligner: hunts K28.5 commas, locks the word boundary and tags each
// emitted code group with its entering running disparity. Define ALIGN_STATS_EN to add realign_cnt.
module comma_word_aligner #(
    parameter int         LOCK_COMMAS     = 3,
    parameter int         UNLOCK_MISALIGN = 2,
    parameter logic [9:0] COMMA_P         = 10'b0011111010,
    parameter logic [9:0] COMMA_N         = 10'b1100000101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_bit,
    input  logic        rx_valid,
    output logic [9:0]  word_out,
    output logic        word_valid,
    output logic        rd_out,
    output logic        comma_det,
    output logic        locked
`ifdef ALIGN_STATS_EN
    ,
    output logic [15:0] realign_cnt
`endif
);

    // state  | meaning
    // HUNT   | no boundary known, any comma anchors
    // CHECK  | anchored, counting aligned commas toward lock
    // LOCKED | boundary trusted, misaligned commas tolerated up to threshold
    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam logic [3:0] LOCK_N    = 4'(LOCK_COMMAS);
    localparam logic [3:0] UNLOCK_N  = 4'(UNLOCK_MISALIGN);
    localparam state_t     ANCHOR_ST = (LOCK_COMMAS == 1) ? LOCKED : CHECK;

    state_t      state;
    logic [8:0]  sr;
    logic [3:0]  bcnt;
    logic [3:0]  comma_cnt;
    logic [3:0]  mis_cnt;
    logic        disp;

    logic [9:0]  nxt;
    logic        match;
    logic        is_n;
    logic        complete;
    logic        anchor;
    logic [3:0]  ones;
    logic        flip;

    function automatic logic [3:0] popcnt(input logic [9:0] w);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 10; i++) c = c + {3'b000, w[i]};
        return c;
    endfunction

    assign nxt      = {sr, rx_bit};
    assign is_n     = (nxt == COMMA_N);
    assign match    = (nxt == COMMA_P) || is_n;
    assign complete = (bcnt == 4'd9);
    assign ones     = popcnt(nxt);
    // Violations (ones outside 4..6) hold disparity; the decoder flags them.
    assign flip     = (ones == 4'd4) || (ones == 4'd6);
    assign anchor   = match && ((state == HUNT) ||
                      (!complete && ((state == CHECK) || (mis_cnt + 4'd1 >= UNLOCK_N))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sr         <= '0;
            bcnt       <= '0;
            comma_cnt  <= '0;
            mis_cnt    <= '0;
            disp       <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
            rd_out     <= 1'b0;
            locked     <= 1'b0;
`ifdef ALIGN_STATS_EN
            realign_cnt <= '0;
`endif
        end else begin
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
            if (rx_valid) begin
                sr <= nxt[8:0];
                if (anchor) begin
                    bcnt       <= '0;
                    comma_cnt  <= 4'd1;
                    mis_cnt    <= '0;
                    word_out   <= nxt;
                    word_valid <= 1'b1;
                    comma_det  <= 1'b1;
                    rd_out     <= is_n;
                    disp       <= ~is_n;
                    state      <= ANCHOR_ST;
                    locked     <= (ANCHOR_ST == LOCKED);
`ifdef ALIGN_STATS_EN
                    if (state != HUNT && realign_cnt != 16'hFFFF)
                        realign_cnt <= realign_cnt + 16'd1;
`endif
                end else if (state != HUNT) begin
                    if (complete) begin
                        bcnt       <= '0;
                        word_out   <= nxt;
                        word_valid <= 1'b1;
                        rd_out     <= disp;
                        if (flip) disp <= ~disp;
                        if (match) begin
                            comma_det <= 1'b1;
                            if (state == CHECK) begin
                                comma_cnt <= comma_cnt + 4'd1;
                                if (comma_cnt + 4'd1 >= LOCK_N) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                mis_cnt <= '0;
                            end
                        end
                    end else begin
                        bcnt <= bcnt + 4'd1;
                        // Only LOCKED reaches here on a match; below threshold it just counts.
                        if (match) mis_cnt <= mis_cnt + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_comma_word_aligner.sv
// Randomized bench for comma_word_aligner against a bit-history reference model.
// Word boundaries in the model come from the count of bits since the last anchor.
module tb_comma_word_aligner;

    localparam logic [9:0] KP   = 10'b0011111010;
    localparam logic [9:0] KN   = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam int LOCK   = 3;
    localparam int UNLOCK = 2;
    localparam int S_HUNT = 0, S_CHECK = 1, S_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_bit;
    logic        rx_valid;
    logic [9:0]  word_out;
    logic        word_valid;
    logic        rd_out;
    logic        comma_det;
    logic        locked;
`ifdef ALIGN_STATS_EN
    logic [15:0] realign_cnt;
`endif

    comma_word_aligner #(
        .LOCK_COMMAS(LOCK), .UNLOCK_MISALIGN(UNLOCK), .COMMA_P(KP), .COMMA_N(KN)
    ) dut (
        .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .word_out(word_out), .word_valid(word_valid), .rd_out(rd_out),
        .comma_det(comma_det), .locked(locked)
`ifdef ALIGN_STATS_EN
        , .realign_cnt(realign_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          hist[$];
    int          m_state, m_since, m_commas, m_mis;
    bit          m_disp;
    logic [9:0]  e_word;
    bit          e_wv, e_cd, e_rd, e_lk;
    int          e_rc;

    function automatic int ones_of(input logic [9:0] w);
        int c = 0;
        for (int i = 0; i < 10; i++) c += int'(w[i]);
        return c;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < 10; i++) hist.push_back(1'b0);
        m_state = S_HUNT; m_since = 0; m_commas = 0; m_mis = 0; m_disp = 0;
        e_word = '0; e_wv = 0; e_cd = 0; e_rd = 0; e_lk = 0; e_rc = 0;
    endtask

    task automatic model_anchor(input logic [9:0] w);
        if (m_state != S_HUNT && e_rc < 65535) e_rc++;
        m_since = 0; m_commas = 1; m_mis = 0;
        e_wv = 1; e_cd = 1; e_word = w;
        e_rd = (w == KN);
        m_disp = !e_rd;
        m_state = (LOCK == 1) ? S_LOCKED : S_CHECK;
    endtask

    task automatic model_step(input bit b, input bit v, input bit r);
        logic [9:0] w;
        bit is_comma, wc;
        int n;
        if (r) begin
            model_reset();
            return;
        end
        e_wv = 0; e_cd = 0;
        if (v) begin
            hist.push_back(b);
            void'(hist.pop_front());
            w = '0;
            for (int i = 0; i < 10; i++) w = {w[8:0], hist[i]};
            is_comma = (w == KP) || (w == KN);
            if (m_state != S_HUNT) m_since++;
            wc = (m_state != S_HUNT) && (m_since % 10 == 0);
            if (m_state == S_HUNT) begin
                if (is_comma) model_anchor(w);
            end else if (wc) begin
                e_wv = 1; e_word = w; e_rd = m_disp;
                n = ones_of(w);
                if (n == 4 || n == 6) m_disp = !m_disp;
                if (is_comma) begin
                    e_cd = 1;
                    if (m_state == S_CHECK) begin
                        m_commas++;
                        if (m_commas >= LOCK) m_state = S_LOCKED;
                    end else begin
                        m_mis = 0;
                    end
                end
            end else if (is_comma) begin
                if (m_state == S_CHECK) model_anchor(w);
                else begin
                    m_mis++;
                    if (m_mis >= UNLOCK) model_anchor(w);
                end
            end
        end
        e_lk = (m_state == S_LOCKED);
    endtask

    task automatic step(input bit b, input bit v, input bit r);
        rx_bit = b; rx_valid = v; rst = r;
        @(posedge clk);
        model_step(b, v, r);
        #1;
        chk("word_valid", 16'(word_valid), 16'(e_wv));
        chk("comma_det",  16'(comma_det),  16'(e_cd));
        chk("locked",     16'(locked),     16'(e_lk));
        chk("rd_out",     16'(rd_out),     16'(e_rd));
        chk("word_out",   16'(word_out),   16'(e_word));
`ifdef ALIGN_STATS_EN
        chk("realign_cnt", realign_cnt, 16'(e_rc));
`endif
    endtask

    // gap: 0 = none, 1 = idle before every bit, 2 = random idle bursts
    task automatic send_bit(input bit b, input int gap);
        if (gap == 1) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        else if (gap == 2 && $urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(b, 1'b1, 1'b0);
    endtask

    task automatic send_word(input logic [9:0] w, input int gap);
        for (int i = 9; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic send_groups(input int n, input int gap);
        repeat (n) begin
            send_word(KP, gap); send_word(D215, gap);
            send_word(KN, gap); send_word(D215, gap);
        end
    endtask

    function automatic bit early_comma(input logic [6:0] r);
        logic [26:0] s;
        s = {10'b0, r, KP};
        for (int i = 1; i <= 17; i++)
            if (s[i +: 10] == KP || s[i +: 10] == KN) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [6:0] lead;
        int tries;
        logic [9:0] junk;
        rst = 1'b1; rx_bit = 1'b0; rx_valid = 1'b0;
        model_reset();

        repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);

        tries = 0;
        lead = 7'($urandom_range(0, 127));
        while (early_comma(lead) && tries < 100) begin
            lead = 7'($urandom_range(0, 127));
            tries++;
        end
        for (int i = 6; i >= 0; i--) send_bit(lead[i], 0);
        send_groups(2, 0);
        chk("lock_after_3", 16'(locked), 16'd1);

        // One extra bit shifts a single comma off the boundary, then restore it.
        send_bit(1'b0, 0);
        send_word(KP, 0);
        junk = D215;
        for (int i = 9; i >= 1; i--) send_bit(junk[i], 0);
        send_groups(2, 0);
        chk("lock_kept_1mis", 16'(locked), 16'd1);

        // Shift by 3 permanently: second misaligned comma re-anchors.
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_word(KP, 0); send_word(D215, 0);
        send_word(KN, 0);
        chk("realign_unlock", 16'(locked), 16'd0);
        chk("realign_rd", 16'(rd_out), 16'd1);
        send_word(D215, 0); send_word(KP, 0); send_word(D215, 0); send_word(KN, 0);
        chk("relock_after_2", 16'(locked), 16'd1);
`ifdef ALIGN_STATS_EN
        chk("realign_cnt_1", realign_cnt, 16'd1);
`endif
        send_word(D215, 0);

        send_groups(2, 1);
        repeat (6) begin
            send_word(($urandom_range(0, 1) != 0) ? KP : KN, 2);
            send_word(10'($urandom_range(0, 1023)), 2);
        end
        send_groups(4, 0);
        chk("lock_before_rst", 16'(locked), 16'd1);

        // Reset mid-word while locked.
        for (int i = 9; i >= 6; i--) send_bit(KP[i], 0);
        step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_word", 16'(word_out), 16'd0);
        send_word(KP, 0); send_word(D215, 0); send_word(KN, 0); send_word(D215, 0);
        chk("relock_need3", 16'(locked), 16'd0);
        send_word(KP, 0);
        chk("relock_3", 16'(locked), 16'd1);
        send_word(D215, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
